// File: rtl/arith_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arith_pkg: shared chunk width, FSM state type and sizing helper.  Rev 1.0
// ---------------------------------------------------------------------------
package arith_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width);
    return width / CHUNK_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bk4_sub_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk4_sub_slice: combinational 4-bit Brent-Kung prefix adder slice.  Rev 1.0
// ---------------------------------------------------------------------------
module bk4_sub_slice (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3_in
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_g10, w_p10, w_g32, w_p32, w_g30, w_p30;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Black cells: pairwise (1:0), (3:2), then (3:0) up the tree.
  assign w_g10 = w_g[1] | (w_p[1] & w_g[0]);
  assign w_p10 = w_p[1] & w_p[0];
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g30 = w_g32 | (w_p32 & w_g10);
  assign w_p30 = w_p32 & w_p10;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g10  | (w_p10  & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_c[2]);

  assign o_sum   = w_p ^ w_c;
  assign o_cout  = w_g30 | (w_p30 & i_cin);
  assign o_c3_in = w_c[3];
endmodule
`default_nettype wire

// File: rtl/seq_prefix_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_prefix_subtractor: multi-cycle a - b - bin, one 4-bit chunk per cycle.  Rev 1.0
// ---------------------------------------------------------------------------
module seq_prefix_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int c_num_chunks = num_chunks(WIDTH);
  localparam int c_cnt_w      = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_chunks - 1);

  generate
    if ((WIDTH % CHUNK_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("seq_prefix_subtractor: WIDTH must be a multiple of 4 and at least 8");
    end
  endgenerate

  state_t                   r_state;
  logic [c_cnt_w-1:0]       r_cnt;
  logic                     r_carry;
  logic [WIDTH-1:0]         r_a;
  logic [WIDTH-1:0]         r_nb;
  logic [WIDTH-CHUNK_W-1:0] r_work;

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_sum;
  logic               w_cout;
  logic               w_c3_in;
  logic [WIDTH-1:0]   w_next;

  assign w_a_chunk = r_a [int'(r_cnt) * CHUNK_W +: CHUNK_W];
  assign w_b_chunk = r_nb[int'(r_cnt) * CHUNK_W +: CHUNK_W];

  bk4_sub_slice u_slice (
    .i_a     (w_a_chunk),
    .i_b     (w_b_chunk),
    .i_cin   (r_carry),
    .o_sum   (w_sum),
    .o_cout  (w_cout),
    .o_c3_in (w_c3_in)
  );

  // Finished chunks shift down from the top; after the last chunk the low
  // WIDTH-4 bits hold chunks 0..N-2 in order and w_sum supplies the top.
  assign w_next = {w_sum, r_work};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_nb      <= '0;
      r_work    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_diff  <= '0;
      out_bout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a      <= in_a;
            r_nb     <= ~in_b;
            r_carry  <= ~in_bin;
            r_cnt    <= '0;
            r_state  <= ST_RUN;
            in_ready <= 1'b0;
          end
        end
        ST_RUN: begin
          r_carry <= w_cout;
          r_work  <= w_next[WIDTH-1:CHUNK_W];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state   <= ST_DONE;
            out_valid <= 1'b1;
            out_diff  <= w_next;
            out_bout  <= ~w_cout;
            out_ovf   <= w_c3_in ^ w_cout;
            out_zero  <= (w_next == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/seq_prefix_subtractor.md
Name: seq_prefix_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor. It computes diff = a − b − bin as the inverse operation of the team's prefix adders.
- It processes one 4-bit chunk per cycle through a Brent-Kung prefix slice and chains the carry in a register.
- Valid/ready handshakes on input and output let it sit between pipeline stages in the arithmetic datapath.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 8; elaboration error otherwise.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block idle and accepting operands
- in_a  input  WIDTH  minuend
- in_b  input  WIDTH  subtrahend
- in_bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_diff  output  WIDTH  a − b − bin, modulo 2^WIDTH
- out_bout  output  1  unsigned borrow out
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_diff == 0

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, chunk counter=0, carry register=0, operand and result registers=0.
  - Outputs during reset: in_ready=1, out_valid=0, out_diff=0, out_bout=0, out_ovf=0, out_zero=0.
- FSM states and transitions:
  - IDLE → RUN on in_valid&&in_ready.
  - RUN → DONE after the last chunk.
  - DONE → IDLE on out_ready.
- IDLE:
  - in_ready=1.
  - On handshake, latch in_a, ~in_b and carry = ~in_bin; clear the counter.
- RUN:
  - in_ready=0.
  - Each cycle, slice k=counter computes s_k = a[4k+3:4k] + nb[4k+3:4k] + carry using the 4-bit prefix network (g=a&b, p=a^b, black/grey combine, sum=p^carry_prefix).
  - Writes s_k into diff[4k+3:4k] and registers the slice carry-out.
  - On the last chunk (k=WIDTH/4−1), also registers c_msb_in, the carry into bit WIDTH−1.
  - Counter increments; after chunk WIDTH/4−1, go to DONE.
- DONE:
  - out_valid=1.
  - Flags: out_bout = ~final_carry; out_ovf = c_msb_in ^ final_carry; out_zero = (diff==0).
  - out_diff and all flags are held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle; there is no same-cycle re-accept.
- Latency: out_valid is first high WIDTH/4 cycles after the accepting edge (4 for WIDTH=16). Throughput is one operation per WIDTH/4+2 cycles minimum.
- Outputs are registered. out_diff/flags change only on the RUN→DONE transition and retain their last value in IDLE.
- Inputs:
  - in_valid is ignored in RUN/DONE, and in_a/in_b/in_bin may change freely there.
  - X on inputs while in_valid=0 has no effect.
- Boundary cases:
  - a==b, bin=0: diff=0, zero=1, bout=0.
  - a<b unsigned: bout=1.
  - Most-negative operand cases flag ovf per the two's-complement rule.
  - bin=1 with a==b: diff all-ones, bout=1.
- Reset mid-RUN or mid-DONE aborts the operation. No result is emitted; outputs take reset values immediately (asynchronously).

Decomposition:
- Shared package arith_pkg:
  - CHUNK_W=4 constant.
  - State typedef (IDLE, RUN, DONE).
  - Function num_chunks(WIDTH).
- Sub-module bk4_sub_slice: combinational 4-bit Brent-Kung prefix slice.
  - Inputs a[3:0], b[3:0], cin.
  - Outputs sum[3:0], cout, c3_in (carry into bit 3).
  - Internals: pre-processing, black/grey cells, post XOR.
- The top level owns the FSM, counter, carry and operand/result registers, and instantiates one slice muxed by chunk index.

Test Plan:
- a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0, ovf=0, zero=0; out_valid exactly 4 cycles after accept edge; in_ready low throughout.
- a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1, ovf=0, zero=0.
- a=0x8000, b=0x0001, bin=0 → diff=0x7FFF, bout=0, ovf=1; a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- a=0x5A5A, b=0x5A59, bin=1 → diff=0x0000, zero=1, bout=0; then a=b=0x00FF, bin=1 → diff=0xFFFF, bout=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid/in_a → out_diff/flags stable, in_ready=0, no second capture; out_ready=1 → IDLE, in_ready=1 next cycle.
- Assert rst_n=0 during RUN chunk 2 → out_valid=0 and all outputs 0 immediately; after release in_ready=1, a fresh operation 0x0003−0x0005 yields 0xFFFE, bout=1.
- Random 10k operations at WIDTH=16 and WIDTH=32 against a reference model, with random out_ready stalls.
